ring_seq_checker: RTL

//  Downstream monitor for the one-hot ring counter bus. Samples ring_in, locks onto the rotation,
//  and verifies that each sample is the expected next state. Rotation is LSB-ward-in,
//  MSB-wraps-to-LSB: 1000->0001->0010->0100->1000.

---
 rtl/ring_seq_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ring_seq_checker.sv
// Purpose: monitors a one-hot ring counter bus, locks onto its rotation, and flags, counts and codes sequence errors.
// Latency: every output is registered and reflects a sample one clk after that sample is presented with ring_vld.
// Backpressure: none; ring_vld=0 freezes all state. Optional macro RING_CHK_RESYNC_EN lets the checker relock from ERROR.
module ring_seq_checker #(
    parameter int W     = 4,
    parameter int CNT_W = 8,
    parameter int REV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     ring_in,
    input  logic             ring_vld,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic [REV_W-1:0] rev_cnt,
    output logic             rev_tick
);

    localparam logic [W-1:0] START_PAT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     exp_q, exp_nxt;
    logic             err_nxt, locked_nxt, tick_nxt;
    logic [1:0]       code_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [REV_W-1:0] rev_nxt;

    logic       zero_hot, one_hot, multi_hot, match;
    logic [1:0] cause;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    // Classify the current sample and pick the error cause it would report
    always_comb begin
        zero_hot  = (ring_in == '0);
        one_hot   = $onehot(ring_in);
        multi_hot = !zero_hot && !one_hot;
        match     = (ring_in == exp_q);
        cause     = zero_hot ? 2'b01 : (multi_hot ? 2'b10 : 2'b11);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: clear wins over a same-cycle sample; idle cycles hold
    always_comb begin
        state_nxt = state;
        if (err_clr) begin
            state_nxt = IDLE;
        end else if (ring_vld) begin
            case (state)
                IDLE:    state_nxt = one_hot ? TRACK : ERROR;
                TRACK:   state_nxt = match ? TRACK : ERROR;
`ifdef RING_CHK_RESYNC_EN
                ERROR:   state_nxt = one_hot ? TRACK : ERROR;
`else
                ERROR:   state_nxt = ERROR;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output next-values: error capture, expected-pattern advance and revolution counting
    always_comb begin
        exp_nxt    = exp_q;
        err_nxt    = err;
        code_nxt   = err_code;
        cnt_nxt    = err_cnt;
        rev_nxt    = rev_cnt;
        tick_nxt   = 1'b0;
        locked_nxt = (state_nxt == TRACK);
        if (err_clr) begin
            exp_nxt  = '0;
            err_nxt  = 1'b0;
            code_nxt = 2'b00;
            cnt_nxt  = '0;
        end else if (ring_vld) begin
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        exp_nxt = rotl(ring_in);
                    end else begin
                        err_nxt  = 1'b1;
                        code_nxt = cause;
                        cnt_nxt  = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
                    end
                end
                TRACK: begin
                    if (match) begin
                        exp_nxt = rotl(exp_q);
                        if (ring_in == START_PAT) begin
                            rev_nxt  = rev_cnt + REV_W'(1);
                            tick_nxt = 1'b1;
                        end
                    end else begin
                        err_nxt  = 1'b1;
                        code_nxt = cause;
                        cnt_nxt  = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
                    end
                end
`ifdef RING_CHK_RESYNC_EN
                ERROR: begin
                    if (one_hot) begin
                        exp_nxt = rotl(ring_in);
                    end else begin
                        code_nxt = cause;
                        cnt_nxt  = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    exp_nxt = exp_q;
                end
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q    <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            err_cnt  <= '0;
            rev_cnt  <= '0;
            rev_tick <= 1'b0;
        end else begin
            exp_q    <= exp_nxt;
            locked   <= locked_nxt;
            err      <= err_nxt;
            err_code <= code_nxt;
            err_cnt  <= cnt_nxt;
            rev_cnt  <= rev_nxt;
            rev_tick <= tick_nxt;
        end
    end

endmodule
